wishbone_master: RTL and testbench

- Command-driven Wishbone classic single-transfer master. It sits directly upstream of wishbone_slave and drives its adr/dat_mosi/we/cyc/stb.
- Accepts one read or write command at a time from a valid/ready command port and runs exactly one bus cycle per command.
- Returns read data or an error on a valid/ready response port.
- A watchdog aborts any cycle the slave never acknowledges (e.g. a slave that has stopped acking), so the bus cannot hang.

---
 rtl/wb_pkg.sv | 37 +++
 rtl/wb_timeout_ctr.sv | 44 ++++
 rtl/wishbone_master.sv | 213 +++++++++++++++++++++
 tb/tb_wishbone_master.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and defaults for the Wishbone classic master.
//                Default bus widths, the master state encoding and packed
//                command/response records for upstream users.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Default bus widths used by the master's parameters.
    localparam int c_adr_w = 4;
    localparam int c_dat_w = 32;

    // Master state encoding. Explicit 2-bit width keeps the register size
    // fixed regardless of tool defaults.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Command record as presented on the command port (default widths).
    typedef struct packed {
        logic               we;
        logic [c_adr_w-1:0] adr;
        logic [c_dat_w-1:0] dat;
    } wb_cmd_t;

    // Response record as presented on the response port (default widths).
    typedef struct packed {
        logic               err;
        logic [c_dat_w-1:0] dat;
    } wb_rsp_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : wb_timeout_ctr
//  Description : Bus-cycle watchdog. Counts enabled cycles since the last
//                clear and flags expiry once TIMEOUT-1 cycles have elapsed,
//                i.e. during the TIMEOUT-th enabled cycle.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                clr          - return count to zero (priority over en)
//                en           - advance count by one
//                expired      - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            c_cw    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(TIMEOUT - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    logic [c_cw-1:0] r_count;
    logic            w_expired;

    assign w_expired = (r_count == c_last);
    assign expired   = w_expired;

    // Holding at the terminal value guarantees the counter can never wrap
    // even if the owner keeps it enabled past expiry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && !w_expired) begin
            r_count <= r_count + c_one;
        end
    end

endmodule : wb_timeout_ctr
`default_nettype wire

// File: rtl/wishbone_master.sv
`default_nettype none
// ============================================================================
//  Module      : wishbone_master
//  Description : Command-driven Wishbone classic single-transfer master.
//                Accepts one read/write command at a time, runs exactly one
//                bus cycle for it and returns read data or a timeout error.
//                A watchdog aborts cycles the slave never acknowledges.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                cmd_valid/ready/we/adr/dat - command port (valid/ready)
//                rsp_valid/ready/dat/err  - response port (valid/ready)
//                err_count                - saturating timeout count
//                adr/dat_mosi/dat_miso/we/cyc/stb/ack - Wishbone master side
//  Revision    : 1.0 - initial release
// ============================================================================
module wishbone_master
    import wb_pkg::*;
#(
    parameter int ADR_W   = c_adr_w,
    parameter int DAT_W   = c_dat_w,
    parameter int TIMEOUT = 16,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    // command port
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    // response port
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic [ERR_W-1:0] err_count,
    // Wishbone
    output logic [ADR_W-1:0] adr,
    output logic [DAT_W-1:0] dat_mosi,
    input  logic [DAT_W-1:0] dat_miso,
    output logic             we,
    output logic             cyc,
    output logic             stb,
    input  logic             ack
);

    localparam logic [ERR_W-1:0] c_err_max = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] c_err_one = ERR_W'(1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    wb_state_e        r_state;
    wb_state_e        w_state_nxt;

    logic [ADR_W-1:0] r_adr,       w_adr_nxt;
    logic [DAT_W-1:0] r_dat_mosi,  w_dat_mosi_nxt;
    logic             r_we,        w_we_nxt;
    logic             r_cyc,       w_cyc_nxt;
    logic             r_stb,       w_stb_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic             r_rsp_err,   w_rsp_err_nxt;
    logic [DAT_W-1:0] r_rsp_dat,   w_rsp_dat_nxt;
    logic [ERR_W-1:0] r_err_count, w_err_count_nxt;

    logic             w_tmo_clr;
    logic             w_tmo_en;
    logic             w_expired;

    // ------------------------------------------------------------------
    // Watchdog: held clear outside BUS so every bus cycle starts at zero;
    // it only advances while the slave is withholding ack.
    // ------------------------------------------------------------------
    assign w_tmo_clr = (r_state != BUS);
    assign w_tmo_en  = (r_state == BUS) && !ack;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_tmo_clr),
        .en      (w_tmo_en),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid)            w_state_nxt = BUS;
            BUS:     if (ack || w_expired)     w_state_nxt = RESP;
            RESP:    if (rsp_ready)            w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: output decode. Produces the next values of every
    // registered output; anything not touched below holds its value.
    // ------------------------------------------------------------------
    always_comb begin
        w_adr_nxt       = r_adr;
        w_dat_mosi_nxt  = r_dat_mosi;
        w_we_nxt        = r_we;
        w_cyc_nxt       = r_cyc;
        w_stb_nxt       = r_stb;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_err_count_nxt = r_err_count;

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_adr_nxt      = cmd_adr;
                    w_we_nxt       = cmd_we;
                    // Reads drive zero so stale write data never leaks out.
                    w_dat_mosi_nxt = cmd_we ? cmd_dat : '0;
                    w_cyc_nxt      = 1'b1;
                    w_stb_nxt      = 1'b1;
                end
            end
            BUS: begin
                // ack is tested first so it wins over a simultaneous expiry.
                if (ack) begin
                    w_cyc_nxt       = 1'b0;
                    w_stb_nxt       = 1'b0;
                    w_we_nxt        = 1'b0;
                    w_rsp_dat_nxt   = r_we ? '0 : dat_miso;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                end else if (w_expired) begin
                    w_cyc_nxt       = 1'b0;
                    w_stb_nxt       = 1'b0;
                    w_we_nxt        = 1'b0;
                    w_rsp_dat_nxt   = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    if (r_err_count != c_err_max) begin
                        w_err_count_nxt = r_err_count + c_err_one;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_err_nxt   = 1'b0;
                end
            end
            default: begin
                w_cyc_nxt       = 1'b0;
                w_stb_nxt       = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr       <= '0;
            r_dat_mosi  <= '0;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_dat   <= '0;
            r_err_count <= '0;
        end else begin
            r_adr       <= w_adr_nxt;
            r_dat_mosi  <= w_dat_mosi_nxt;
            r_we        <= w_we_nxt;
            r_cyc       <= w_cyc_nxt;
            r_stb       <= w_stb_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    // cmd_ready depends on registered state only, never on cmd_valid.
    assign cmd_ready = (r_state == IDLE);

    assign adr       = r_adr;
    assign dat_mosi  = r_dat_mosi;
    assign we        = r_we;
    assign cyc       = r_cyc;
    assign stb       = r_stb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_dat   = r_rsp_dat;
    assign err_count = r_err_count;

endmodule : wishbone_master
`default_nettype wire

// File: tb/tb_wishbone_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wishbone_master
//  Description : Directed self-checking bench for wishbone_master. One
//                instance uses the default TIMEOUT of 16, a second uses
//                TIMEOUT=2 for the saturation and ack-on-expiry cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_master;

    logic        clk = 1'b0;
    logic        rst;

    // default-timeout instance
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic [7:0]  err_count;
    logic [3:0]  adr;
    logic [31:0] dat_mosi, dat_miso;
    logic        we, cyc, stb, ack;

    // TIMEOUT=2 instance
    logic        b_cmd_valid, b_cmd_ready, b_cmd_we;
    logic [3:0]  b_cmd_adr;
    logic [31:0] b_cmd_dat;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_dat;
    logic [7:0]  b_err_count;
    logic [3:0]  b_adr;
    logic [31:0] b_dat_mosi, b_dat_miso;
    logic        b_we, b_cyc, b_stb, b_ack;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem_word;   // tiny slave memory: last written word

    always #5 clk = ~clk;

    wishbone_master #(.ADR_W(4), .DAT_W(32), .TIMEOUT(16), .ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .err_count(err_count),
        .adr(adr), .dat_mosi(dat_mosi), .dat_miso(dat_miso),
        .we(we), .cyc(cyc), .stb(stb), .ack(ack)
    );

    wishbone_master #(.ADR_W(4), .DAT_W(32), .TIMEOUT(2), .ERR_W(8)) dut_t2 (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_we(b_cmd_we),
        .cmd_adr(b_cmd_adr), .cmd_dat(b_cmd_dat),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_dat(b_rsp_dat),
        .rsp_err(b_rsp_err), .err_count(b_err_count),
        .adr(b_adr), .dat_mosi(b_dat_mosi), .dat_miso(b_dat_miso),
        .we(b_we), .cyc(b_cyc), .stb(b_stb), .ack(b_ack)
    );

    // Advance one clock and settle just after the active edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1'b0; dat_miso = '0; ack = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_we = 1'b0; b_cmd_adr = '0; b_cmd_dat = '0;
        b_rsp_ready = 1'b0; b_dat_miso = '0; b_ack = 1'b0;
        tick; tick;
        n_vec++;
        if ({cyc, stb, we, rsp_valid, rsp_err, cmd_ready} !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000001", {cyc, stb, we, rsp_valid, rsp_err, cmd_ready});
        end
        n_vec++;
        if ({adr, dat_mosi, rsp_dat, err_count} !== 76'd0) begin
            n_err++;
            $display("FAIL reset_data: got adr=%h mosi=%h rdat=%h errc=%h expected all 0", adr, dat_mosi, rsp_dat, err_count);
        end
        n_vec++;
        if ({b_cyc, b_rsp_valid, b_cmd_ready, b_err_count} !== 11'b00100000000) begin
            n_err++;
            $display("FAIL reset_t2: got cyc=%b rv=%b rdy=%b errc=%h expected 0 0 1 00", b_cyc, b_rsp_valid, b_cmd_ready, b_err_count);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_write;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 4'd1; cmd_dat = 32'hDEADBEEF;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL wr_ready: got %b expected 1", cmd_ready);
        end
        tick;
        cmd_valid = 1'b0;
        n_vec++;
        if ({cyc, stb, we, cmd_ready, rsp_valid} !== 5'b11100) begin
            n_err++; $display("FAIL wr_bus_ctrl: got %b expected 11100", {cyc, stb, we, cmd_ready, rsp_valid});
        end
        n_vec++;
        if (adr !== 4'd1 || dat_mosi !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL wr_bus_data: got adr=%h mosi=%h expected 1 DEADBEEF", adr, dat_mosi);
        end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        mem_word = 32'hDEADBEEF;
        n_vec++;
        if ({cyc, stb, we, rsp_valid, rsp_err} !== 5'b00010 || rsp_dat !== 32'h0) begin
            n_err++; $display("FAIL wr_resp: got ctrl=%b rdat=%h expected 00010 0", {cyc, stb, we, rsp_valid, rsp_err}, rsp_dat);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_err++; $display("FAIL wr_handshake: got rv=%b rdy=%b expected 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 4'd1; cmd_dat = 32'hFFFFFFFF;
        tick;
        cmd_valid = 1'b0;
        n_vec++;
        if ({cyc, stb, we} !== 3'b110 || dat_mosi !== 32'h0 || adr !== 4'd1) begin
            n_err++; $display("FAIL rd_bus: got ctrl=%b mosi=%h adr=%h expected 110 0 1", {cyc, stb, we}, dat_mosi, adr);
        end
        ack = 1'b1; dat_miso = mem_word;
        tick;
        ack = 1'b0; dat_miso = 32'hA5A5A5A5;
        n_vec++;
        if ({cyc, rsp_valid, rsp_err} !== 3'b010 || rsp_dat !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL rd_resp: got ctrl=%b rdat=%h expected 010 DEADBEEF", {cyc, rsp_valid, rsp_err}, rsp_dat);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int n;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 4'd2;
        tick;
        cmd_valid = 1'b0;
        n = 0;
        while (cyc && n < 40) begin
            n++;
            tick;
        end
        n_vec++;
        if (n !== 16) begin
            n_err++; $display("FAIL tmo_len: got %0d bus cycles expected 16", n);
        end
        n_vec++;
        if ({cyc, stb, rsp_valid, rsp_err} !== 4'b0011 || rsp_dat !== 32'h0 || err_count !== 8'd1) begin
            n_err++; $display("FAIL tmo_resp: got ctrl=%b rdat=%h errc=%0d expected 0011 0 1", {cyc, stb, rsp_valid, rsp_err}, rsp_dat, err_count);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n_vec++;
        if ({cmd_ready, rsp_valid, rsp_err} !== 3'b100) begin
            n_err++; $display("FAIL tmo_release: got %b expected 100", {cmd_ready, rsp_valid, rsp_err});
        end
        // next command must still be accepted and complete normally
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 4'd3; cmd_dat = 32'h0BADF00D;
        tick;
        cmd_valid = 1'b0;
        n_vec++;
        if ({cyc, we} !== 2'b11 || adr !== 4'd3 || dat_mosi !== 32'h0BADF00D) begin
            n_err++; $display("FAIL tmo_next_cmd: got ctrl=%b adr=%h mosi=%h expected 11 3 0BADF00D", {cyc, we}, adr, dat_mosi);
        end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_err} !== 2'b10 || err_count !== 8'd1) begin
            n_err++; $display("FAIL tmo_next_resp: got rv/err=%b errc=%0d expected 10 1", {rsp_valid, rsp_err}, err_count);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 4'd1;
        tick;
        cmd_valid = 1'b0;
        ack = 1'b1; dat_miso = 32'h13572468;
        tick;
        ack = 1'b0; dat_miso = 32'h0;
        // a waiting command must not be accepted while the response stalls
        cmd_valid = 1'b1; cmd_adr = 4'd4;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({rsp_valid, rsp_err, cmd_ready, cyc} !== 4'b1000 || rsp_dat !== 32'h13572468) begin
                n_err++; $display("FAIL bp_hold[%0d]: got ctrl=%b rdat=%h expected 1000 13572468", i, {rsp_valid, rsp_err, cmd_ready, cyc}, rsp_dat);
            end
            tick;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n_vec++;
        if ({rsp_valid, cmd_ready} !== 2'b10 || rsp_dat !== 32'h13572468) begin
            n_err++; $display("FAIL bp_cycle6: got ctrl=%b rdat=%h expected 10 13572468", {rsp_valid, cmd_ready}, rsp_dat);
        end
        tick;
        rsp_ready = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_err, cmd_ready, cyc} !== 4'b0010) begin
            n_err++; $display("FAIL bp_release: got %b expected 0010", {rsp_valid, rsp_err, cmd_ready, cyc});
        end
    endtask

    task automatic test_reset_mid_bus;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 4'd3;
        tick;                 // BUS cycle 1
        cmd_valid = 1'b0;
        tick;                 // BUS cycle 2
        tick;                 // BUS cycle 3
        n_vec++;
        if (cyc !== 1'b1 || err_count !== 8'd1) begin
            n_err++; $display("FAIL rst_pre: got cyc=%b errc=%0d expected 1 1", cyc, err_count);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_vec++;
        if ({cyc, stb, rsp_valid, cmd_ready} !== 4'b0001 || err_count !== 8'd0) begin
            n_err++; $display("FAIL rst_mid_bus: got ctrl=%b errc=%0d expected 0001 0", {cyc, stb, rsp_valid, cmd_ready}, err_count);
        end
        tick;
        n_vec++;
        if ({cyc, rsp_valid} !== 2'b00) begin
            n_err++; $display("FAIL rst_no_rsp: got %b expected 00", {cyc, rsp_valid});
        end
        // spurious ack while idle
        ack = 1'b1; dat_miso = 32'hFFFFFFFF;
        tick; tick;
        ack = 1'b0; dat_miso = 32'h0;
        n_vec++;
        if ({cmd_ready, cyc, stb, rsp_valid, rsp_err} !== 5'b10000 || rsp_dat !== 32'h0 || err_count !== 8'd0) begin
            n_err++; $display("FAIL spurious_ack: got ctrl=%b rdat=%h errc=%0d expected 10000 0 0", {cmd_ready, cyc, stb, rsp_valid, rsp_err}, rsp_dat, err_count);
        end
    endtask

    task automatic test_ack_on_timeout;
        b_cmd_valid = 1'b1; b_cmd_we = 1'b0; b_cmd_adr = 4'd5;
        tick;                 // BUS, wait count 0
        b_cmd_valid = 1'b0;
        tick;                 // BUS, wait count 1 = TIMEOUT-1
        n_vec++;
        if (b_cyc !== 1'b1) begin
            n_err++; $display("FAIL t2_bus_cycle2: got cyc=%b expected 1", b_cyc);
        end
        b_ack = 1'b1; b_dat_miso = 32'h12345678;
        tick;
        b_ack = 1'b0; b_dat_miso = 32'h0;
        n_vec++;
        if ({b_cyc, b_rsp_valid, b_rsp_err} !== 3'b010 || b_rsp_dat !== 32'h12345678 || b_err_count !== 8'd0) begin
            n_err++; $display("FAIL t2_ack_wins: got ctrl=%b rdat=%h errc=%0d expected 010 12345678 0", {b_cyc, b_rsp_valid, b_rsp_err}, b_rsp_dat, b_err_count);
        end
        b_rsp_ready = 1'b1;
        tick;
        b_rsp_ready = 1'b0;
    endtask

    task automatic test_saturation;
        int n_rsp;
        int n_tmo;
        int guard;
        logic [7:0] errc_at_100;
        n_rsp = 0; n_tmo = 0; guard = 0; errc_at_100 = '0;
        b_cmd_valid = 1'b1; b_cmd_we = 1'b0; b_cmd_adr = 4'd6; b_rsp_ready = 1'b1;
        while (n_rsp < 260 && guard < 3000) begin
            if (b_rsp_valid) begin
                n_rsp++;
                if (b_rsp_err) n_tmo++;
                if (n_rsp == 100) errc_at_100 = b_err_count;
                if (n_rsp == 260) b_cmd_valid = 1'b0;
            end
            tick;
            guard++;
        end
        b_rsp_ready = 1'b0;
        n_vec++;
        if (n_rsp !== 260 || n_tmo !== 260) begin
            n_err++; $display("FAIL sat_count_rsp: got rsp=%0d tmo=%0d expected 260 260", n_rsp, n_tmo);
        end
        n_vec++;
        if (errc_at_100 !== 8'd100) begin
            n_err++; $display("FAIL sat_mid: got errc=%0d expected 100", errc_at_100);
        end
        n_vec++;
        if (b_err_count !== 8'd255 || b_cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL sat_final: got errc=%0d rdy=%b expected 255 1", b_err_count, b_cmd_ready);
        end
    endtask

    initial begin
        mem_word = '0;
        test_reset;
        test_write;
        test_read;
        test_timeout;
        test_backpressure;
        test_reset_mid_bus;
        test_ack_on_timeout;
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_wishbone_master
`default_nettype wire
